// File: rtl/dec_3to8.sv
// rtl/dec_3to8.sv - registered 3-to-8 one-hot decoder with valid flag and sticky coverage mask
module dec_3to8 #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] a,
    output logic [7:0] l,
    output logic       l_valid,
    output logic [7:0] seen
);

    // Value of l with no line asserted, in the configured polarity.
    localparam logic [7:0] L_IDLE = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0] onehot;
    logic [7:0] l_d;
    logic [7:0] l_q;
    logic       l_valid_d;
    logic       l_valid_q;
    logic [7:0] seen_d;
    logic [7:0] seen_q;

    always_comb begin
        onehot    = 8'd1 << a;
        l_d       = L_IDLE;
        l_valid_d = 1'b0;
        seen_d    = seen_q;
        if (en) begin
            l_d       = ACTIVE_LOW ? ~onehot : onehot;
            l_valid_d = 1'b1;
            seen_d    = seen_q | onehot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_q       <= L_IDLE;
            l_valid_q <= 1'b0;
            seen_q    <= 8'h00;
        end else begin
            l_q       <= l_d;
            l_valid_q <= l_valid_d;
            seen_q    <= seen_d;
        end
    end

    assign l       = l_q;
    assign l_valid = l_valid_q;
    assign seen    = seen_q;

endmodule

// File: tb/tb_dec_3to8.sv
// tb/tb_dec_3to8.sv - scoreboard bench for dec_3to8, both output polarities
module tb_dec_3to8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] a;
    logic [7:0] l_hi;
    logic       vld_hi;
    logic [7:0] seen_hi;
    logic [7:0] l_lo;
    logic       vld_lo;
    logic [7:0] seen_lo;

    int checks;
    int failures;

    typedef struct packed {
        logic [7:0] l_hi;
        logic [7:0] l_lo;
        logic       vld;
        logic [7:0] seen;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_seen;

    dec_3to8 #(.ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk(clk), .rst(rst), .en(en), .a(a),
        .l(l_hi), .l_valid(vld_hi), .seen(seen_hi)
    );

    dec_3to8 #(.ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk(clk), .rst(rst), .en(en), .a(a),
        .l(l_lo), .l_valid(vld_lo), .seen(seen_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called 1 time unit after a rising edge: drive, record expectation, wait past the next edge.
    task automatic drive(input logic e, input logic [2:0] sel);
        exp_t x;
        en = e;
        a  = sel;
        if (e) exp_seen = exp_seen | (8'd1 << sel);
        x.l_hi = e ? (8'd1 << sel) : 8'h00;
        x.l_lo = ~x.l_hi;
        x.vld  = e;
        x.seen = exp_seen;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        exp_seen = 8'h00;
        sb.delete();
    endtask

    task automatic test_reset();
        exp_t x;
        rst = 1'b0; en = 1'b0; a = 3'd0; exp_seen = 8'h00;
        #2;
        en = 1'b1; a = 3'b101; rst = 1'b1;
        #1;
        checks++; if (l_hi !== 8'h00) begin failures++; $display("FAIL reset_l got=%h exp=00", l_hi); end
        checks++; if (l_lo !== 8'hFF) begin failures++; $display("FAIL reset_l_lo got=%h exp=FF", l_lo); end
        checks++; if (vld_hi !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", vld_hi); end
        checks++; if (seen_hi !== 8'h00) begin failures++; $display("FAIL reset_seen got=%h exp=00", seen_hi); end
        @(posedge clk); #1;
        checks++; if (l_hi !== 8'h00 || vld_hi !== 1'b0 || seen_hi !== 8'h00)
            begin failures++; $display("FAIL reset_wins got=%h/%b/%h exp=00/0/00", l_hi, vld_hi, seen_hi); end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 3'b101);
        x = sb.pop_front();
        checks++; if (l_hi !== 8'h20) begin failures++; $display("FAIL release_l got=%h exp=20", l_hi); end
        checks++; if (vld_hi !== x.vld) begin failures++; $display("FAIL release_valid got=%b exp=%b", vld_hi, x.vld); end
    endtask

    task automatic test_sweep();
        exp_t x;
        pulse_reset();
        for (int v = 0; v < 8; v++) begin
            for (int r = 0; r < 3; r++) begin
                drive(1'b1, 3'(v));
                x = sb.pop_front();
                checks++; if (l_hi !== x.l_hi) begin failures++; $display("FAIL sweep_l a=%0d got=%h exp=%h", v, l_hi, x.l_hi); end
                checks++; if (vld_hi !== x.vld) begin failures++; $display("FAIL sweep_valid a=%0d got=%b exp=%b", v, vld_hi, x.vld); end
                checks++; if (seen_hi !== x.seen) begin failures++; $display("FAIL sweep_seen a=%0d got=%h exp=%h", v, seen_hi, x.seen); end
            end
        end
        checks++; if (seen_hi !== 8'hFF) begin failures++; $display("FAIL sweep_seen_final got=%h exp=FF", seen_hi); end
    endtask

    task automatic test_back_to_back();
        exp_t       x;
        logic [2:0] sel_tab [4] = '{3'd3, 3'd6, 3'd0, 3'd7};
        logic [7:0] exp_tab [4] = '{8'h08, 8'h40, 8'h01, 8'h80};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, sel_tab[i]);
            x = sb.pop_front();
            checks++; if (l_hi !== exp_tab[i]) begin failures++; $display("FAIL b2b_l i=%0d got=%h exp=%h", i, l_hi, exp_tab[i]); end
            checks++; if (l_lo !== x.l_lo) begin failures++; $display("FAIL b2b_l_lo i=%0d got=%h exp=%h", i, l_lo, x.l_lo); end
            checks++; if (vld_hi && $countones(l_hi) != 1) begin failures++; $display("FAIL b2b_onehot i=%0d got=%h exp=onehot", i, l_hi); end
        end
    endtask

    task automatic test_enable_gating();
        exp_t x;
        pulse_reset();
        drive(1'b1, 3'd2);
        x = sb.pop_front();
        checks++; if (l_hi !== 8'h04) begin failures++; $display("FAIL gate_l_on got=%h exp=04", l_hi); end
        drive(1'b0, 3'd5);
        x = sb.pop_front();
        checks++; if (l_hi !== x.l_hi) begin failures++; $display("FAIL gate_l_off got=%h exp=%h", l_hi, x.l_hi); end
        checks++; if (vld_hi !== 1'b0) begin failures++; $display("FAIL gate_valid got=%b exp=0", vld_hi); end
        checks++; if (seen_hi !== 8'h04) begin failures++; $display("FAIL gate_seen got=%h exp=04", seen_hi); end
        checks++; if (l_lo !== 8'hFF) begin failures++; $display("FAIL gate_l_lo got=%h exp=FF", l_lo); end
    endtask

    task automatic test_reset_mid();
        exp_t x;
        pulse_reset();
        drive(1'b1, 3'd1);
        x = sb.pop_front();
        drive(1'b1, 3'd4);
        x = sb.pop_front();
        checks++; if (seen_hi !== 8'h12) begin failures++; $display("FAIL mid_seen_pre got=%h exp=12", seen_hi); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (l_hi !== 8'h00 || vld_hi !== 1'b0 || seen_hi !== 8'h00)
            begin failures++; $display("FAIL mid_async got=%h/%b/%h exp=00/0/00", l_hi, vld_hi, seen_hi); end
        @(posedge clk); #1;
        checks++; if (seen_hi !== 8'h00 || l_lo !== 8'hFF)
            begin failures++; $display("FAIL mid_hold got=%h/%h exp=00/FF", seen_hi, l_lo); end
        rst = 1'b0;
        exp_seen = 8'h00;
        drive(1'b1, 3'd7);
        x = sb.pop_front();
        checks++; if (l_hi !== 8'h80) begin failures++; $display("FAIL mid_after_l got=%h exp=80", l_hi); end
        checks++; if (seen_hi !== x.seen) begin failures++; $display("FAIL mid_after_seen got=%h exp=%h", seen_hi, x.seen); end
    endtask

    task automatic test_polarity();
        exp_t       x;
        logic [7:0] exp_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        pulse_reset();
        for (int v = 0; v < 8; v++) begin
            drive(1'b1, 3'(v));
            x = sb.pop_front();
            checks++; if (l_lo !== exp_tab[v]) begin failures++; $display("FAIL pol_l a=%0d got=%h exp=%h", v, l_lo, exp_tab[v]); end
            checks++; if (vld_lo !== x.vld) begin failures++; $display("FAIL pol_valid a=%0d got=%b exp=%b", v, vld_lo, x.vld); end
        end
        checks++; if (seen_lo !== 8'hFF) begin failures++; $display("FAIL pol_seen got=%h exp=FF", seen_lo); end
        drive(1'b0, 3'd3);
        x = sb.pop_front();
        checks++; if (l_lo !== 8'hFF) begin failures++; $display("FAIL pol_l_off got=%h exp=FF", l_lo); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sweep();
        test_back_to_back();
        test_enable_gating();
        test_reset_mid();
        test_polarity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
